lut_ram_loader: RTL and testbench

Upstream feeder for the LUT RAM write port. It accepts a byte stream over a valid/ready handshake, for example from a UART receiver or a debug host. It assembles little-endian LUT_WIDTH-bit words and issues one-cycle writes to consecutive addresses starting at 0. Its job is to preload instruction/data memory before the core is released, and it reports completion or an illegal request with a done/err pulse.

---
 rtl/lut_ram_loader.sv | 121 ++++++++++++
 tb/tb_lut_ram_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_ram_loader.sv
// Byte-stream loader that packs little-endian words and writes them
// to consecutive LUT RAM addresses starting at zero.
module lut_ram_loader #(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 256,
  localparam int AW = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW:0]          num_words,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [LUT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int BPW = LUT_WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(LUT_DEPTH);
  localparam logic [BCW-1:0] LAST_LANE = BCW'(BPW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state;
  logic [AW:0]          nw_q;
  logic [AW-1:0]        addr_q;
  logic [BCW-1:0]       byte_cnt;
  logic [LUT_WIDTH-1:0] asm_q;
  logic [LUT_WIDTH-1:0] asm_next;
  logic                 last_word;

  assign byte_ready = (state == S_COLLECT);
  assign busy       = (state != S_IDLE);
  assign last_word  = ({1'b0, addr_q} == (nw_q - (AW+1)'(1)));

  // Drop the incoming byte into the lane selected by byte_cnt.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < BPW; i++) begin
      if (byte_cnt == BCW'(i)) begin
        asm_next[8*i +: 8] = byte_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      nw_q     <= '0;
      addr_q   <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            nw_q <= num_words;
            if (num_words == '0 || num_words > DEPTH_W) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= S_COLLECT;
              addr_q   <= '0;
              byte_cnt <= '0;
              err      <= 1'b0;
            end
          end
        end
        S_COLLECT: begin
          if (byte_valid) begin
            asm_q <= asm_next;
            if (byte_cnt == LAST_LANE) begin
              byte_cnt <= '0;
              state    <= S_WRITE;
              wr_en    <= 1'b1;
              wr_addr  <= addr_q;
              wr_data  <= asm_next;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        S_WRITE: begin
          wr_en <= 1'b0;
          // Leave before incrementing so a full-depth load never wraps.
          if (last_word) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            addr_q <= addr_q + AW'(1);
            state  <= S_COLLECT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_ram_loader.sv
// Directed bench for lut_ram_loader with a LUT RAM model fed by
// a negedge monitor.
module tb_lut_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  lut_ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:255];
  int addr_log [0:299];
  int wr_cnt, done_cnt, ready_cnt, viol;
  int last_wr_cyc, done_cyc, last_xfer_cyc;
  logic last_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        mem[wr_addr] = wr_data;
        if (wr_cnt < 300) addr_log[wr_cnt] = int'(wr_addr);
        wr_cnt = wr_cnt + 1;
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        last_err = err;
        done_cyc = cyc;
      end
      if (byte_ready) ready_cnt = ready_cnt + 1;
      if (byte_ready && wr_en) viol = viol + 1;
      if (err && !done) viol = viol + 1;
      if (byte_ready && !busy) viol = viol + 1;
    end
  end

  task automatic clear_sb();
    wr_cnt = 0; done_cnt = 0; ready_cnt = 0; viol = 0;
    last_wr_cyc = -1; done_cyc = -1; last_xfer_cyc = -1;
    last_err = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 'x;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_words = 9'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] q[$], input int gap_pct);
    int i = 0;
    int c = 0;
    while (i < q.size() && c < 20000) begin
      @(negedge clk);
      c++;
      if (int'($urandom_range(99)) < gap_pct) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data = q[i];
        if (byte_ready) begin
          i++;
          last_xfer_cyc = cyc;
        end
      end
    end
    chk_cnt++;
    if (i == q.size()) pass_cnt++;
    else $display("FAIL feed_timeout sent=%0d required=%0d", i, q.size());
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int c = 0;
    while (done_cnt == d0 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk_cnt++;
    if (done_cnt > d0) pass_cnt++;
    else $display("FAIL done_timeout after %0d cycles", c);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk_cnt++;
    if ({byte_ready, wr_en, busy, done, err} !== 5'b0 ||
        wr_addr !== 8'h0 || wr_data !== 32'h0) begin
      $display("FAIL %s ctl=%b addr=%h data=%h required all 0", tag,
               {byte_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    end else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_words = '0;
    byte_valid = 1'b0; byte_data = '0;
    clear_sb();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("idle_after_reset");
  endtask

  task automatic run_two_words(input int gap_pct, input string tag);
    logic [7:0] q[$];
    q = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_sb();
    do_start(2);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start got=%b required=1", tag, busy);
    else pass_cnt++;
    feed(q, gap_pct);
    wait_done(50);
    chk_cnt++;
    if (wr_cnt !== 2) $display("FAIL %s write_count got=%0d required=2", tag, wr_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (mem[0] !== 32'h12345678) $display("FAIL %s word0 got=%h required=12345678", tag, mem[0]);
    else pass_cnt++;
    chk_cnt++;
    if (mem[1] !== 32'hDEADBEEF) $display("FAIL %s word1 got=%h required=deadbeef", tag, mem[1]);
    else pass_cnt++;
    chk_cnt++;
    if (addr_log[0] != 0 || addr_log[1] != 1)
      $display("FAIL %s addr_order got=%0d,%0d required=0,1", tag, addr_log[0], addr_log[1]);
    else pass_cnt++;
    chk_cnt++;
    if (last_wr_cyc != last_xfer_cyc + 1)
      $display("FAIL %s byte_to_write_latency got=%0d required=1", tag, last_wr_cyc - last_xfer_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (done_cyc != last_wr_cyc + 1)
      $display("FAIL %s write_to_done_latency got=%0d required=1", tag, done_cyc - last_wr_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (last_err !== 1'b0) $display("FAIL %s err got=%b required=0", tag, last_err);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1)
      $display("FAIL %s after_done busy=%b done=%b done_cnt=%0d required 0,0,1", tag, busy, done, done_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (viol != 0) $display("FAIL %s handshake_violations got=%0d required=0", tag, viol);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_two_words(0, "basic");
  endtask

  task automatic test_backpressure();
    run_two_words(40, "gaps");
  endtask

  task automatic test_illegal(input int n);
    clear_sb();
    do_start(n);
    chk_cnt++;
    if (done !== 1'b1 || err !== 1'b1)
      $display("FAIL illegal_%0d done=%b err=%b required 1,1", n, done, err);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL illegal_%0d after done=%b err=%b busy=%b required 0", n, done, err, busy);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (wr_cnt != 0 || ready_cnt != 0 || done_cnt != 1)
      $display("FAIL illegal_%0d wr=%0d ready=%0d done=%0d required 0,0,1", n, wr_cnt, ready_cnt, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_full_depth();
    logic [7:0] q[$];
    int bad_data = 0;
    int bad_addr = 0;
    for (int k = 0; k < 256; k++) begin
      q.push_back(8'(k));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
    end
    clear_sb();
    do_start(256);
    feed(q, 0);
    wait_done(50);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (wr_cnt != 256) $display("FAIL full_write_count got=%0d required=256", wr_cnt);
    else pass_cnt++;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== 32'(k)) bad_data++;
      if (addr_log[k] != k) bad_addr++;
    end
    chk_cnt++;
    if (bad_data != 0) $display("FAIL full_data bad_words=%0d required=0", bad_data);
    else pass_cnt++;
    chk_cnt++;
    if (bad_addr != 0) $display("FAIL full_addr_order bad=%0d required=0", bad_addr);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt != 1 || last_err !== 1'b0)
      $display("FAIL full_done count=%0d err=%b required 1,0", done_cnt, last_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] q[$];
    clear_sb();
    do_start(2);
    q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    feed(q, 0);
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset_mid_word");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (wr_cnt != 1 || done_cnt != 0)
      $display("FAIL reset_mid_writes wr=%0d done=%0d required 1,0", wr_cnt, done_cnt);
    else pass_cnt++;
    clear_sb();
    do_start(1);
    q = {8'h01, 8'h02, 8'h03, 8'h04};
    feed(q, 0);
    wait_done(50);
    chk_cnt++;
    if (wr_cnt != 1 || mem[0] !== 32'h04030201)
      $display("FAIL reset_reload wr=%0d data=%h required 1,04030201", wr_cnt, mem[0]);
    else pass_cnt++;
  endtask

  task automatic test_start_busy();
    logic [7:0] q[$];
    clear_sb();
    do_start(1);
    q = {8'h0D, 8'hF0};
    feed(q, 0);
    do_start(5);
    q = {8'hAD, 8'h0B};
    feed(q, 0);
    wait_done(50);
    repeat (30) @(negedge clk);
    chk_cnt++;
    if (wr_cnt != 1 || mem[0] !== 32'h0BADF00D)
      $display("FAIL start_busy_write wr=%0d data=%h required 1,0badf00d", wr_cnt, mem[0]);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt != 1 || busy !== 1'b0)
      $display("FAIL start_busy_done count=%0d busy=%b required 1,0", done_cnt, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal(0);
    test_illegal(257);
    test_full_depth();
    test_reset_mid_word();
    test_start_busy();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
